mem_responder: RTL and testbench

- Memory-side responder for the CPU's fetch/load/store bus: accepts one request at a time, inserts configurable wait states, then returns a response.
- Implements a byte-wide RAM with a write-protected top region (reset-vector/boot area) and per-byte parity.
- Reports memory violation (MV) and memory corruption (MC) status for the CPU status register, plus a saturating error counter.

---
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with wait states, a
// write-protected boot region, per-byte parity and MV/MC error reporting.
`default_nettype none

module mem_responder #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 8,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ROM_BASE    = 1008
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              rom_wr_en,
    input  logic              inj_parity_err,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_mv,
    output logic              rsp_mc,
    output logic [7:0]        err_count
);

    localparam int         IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_wait_cnt;
    logic              r_we;
    logic              r_rom_wr_en;
    logic              r_inj;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_mv;
    logic              r_rsp_mc;
    logic [7:0]        r_err_count;

    // Storage is deliberately unreset so contents survive a reset pulse.
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic              r_par [MEM_DEPTH];

    logic              w_accept;
    logic              w_rsp_hs;
    logic              w_mapped;
    logic              w_protected;
    logic              w_mv;
    logic              w_mc;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_byte;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_rsp_hs    = (r_state == S_RESP) && rsp_ready;

    // Full-width compares: high address bits never alias into the array.
    assign w_mapped    = r_addr < ADDR_W'(MEM_DEPTH);
    assign w_protected = w_mapped && (r_addr >= ADDR_W'(ROM_BASE));
    assign w_idx       = r_addr[IDX_W-1:0];
    assign w_rd_byte   = r_mem[w_idx];

    always_comb begin
        w_mv    = !w_mapped || (r_we && w_protected && !r_rom_wr_en);
        w_rdata = '0;
        w_mc    = 1'b0;
        if (!r_we && !w_mv) begin
            w_rdata = w_rd_byte;
            w_mc    = r_par[w_idx] != (^w_rd_byte);
        end
        w_wr_en = (r_state == S_EXEC) && r_we && !w_mv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_EXEC;
            S_WAIT: if (r_wait_cnt == C_LAST) w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= '0;
            r_we        <= 1'b0;
            r_rom_wr_en <= 1'b0;
            r_inj       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_mv    <= 1'b0;
            r_rsp_mc    <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_accept) begin
                r_wait_cnt  <= '0;
                r_we        <= req_we;
                r_rom_wr_en <= rom_wr_en;
                r_inj       <= inj_parity_err;
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
            end
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (r_state == S_EXEC) begin
                r_rsp_rdata <= w_rdata;
                r_rsp_mv    <= w_mv;
                r_rsp_mc    <= w_mc;
            end
            if (w_rsp_hs && (r_rsp_mv || r_rsp_mc) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Stored parity is even parity of the byte, flipped by the test hook.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= r_wdata;
            r_par[w_idx] <= (^r_wdata) ^ r_inj;
        end
    end

    assign req_ready = rst_n && (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_mv    = r_rsp_mv;
    assign rsp_mc    = r_rsp_mc;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against
// a byte-array reference model of the access rules.
`default_nettype none

module tb_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 1024;
    localparam int ROMB  = 1008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        use0;
    logic        req_we;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rom_wr_en;
    logic        inj_parity_err;
    logic        rsp_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_mv, a_rsp_mc;
    logic [7:0]  a_rsp_rdata, a_err_count;
    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_mv, z_rsp_mc;
    logic [7:0]  z_rsp_rdata, z_err_count;

    logic        t_req_ready, t_rsp_valid, t_rsp_mv, t_rsp_mc;
    logic [7:0]  t_rsp_rdata, t_err_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_data [DEPTH];
    bit         m_bad  [DEPTH];
    int         m_err;
    int         wr_q[$];

    always #5 clk = ~clk;

    assign a_req_valid = req_valid & ~use0;
    assign z_req_valid = req_valid & use0;
    assign t_req_ready = use0 ? z_req_ready : a_req_ready;
    assign t_rsp_valid = use0 ? z_rsp_valid : a_rsp_valid;
    assign t_rsp_rdata = use0 ? z_rsp_rdata : a_rsp_rdata;
    assign t_rsp_mv    = use0 ? z_rsp_mv    : a_rsp_mv;
    assign t_rsp_mc    = use0 ? z_rsp_mc    : a_rsp_mc;
    assign t_err_count = use0 ? z_err_count : a_err_count;

    mem_responder #(.WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rom_wr_en(rom_wr_en),
        .inj_parity_err(inj_parity_err), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_mv(a_rsp_mv), .rsp_mc(a_rsp_mc), .err_count(a_err_count)
    );

    mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rom_wr_en(rom_wr_en),
        .inj_parity_err(inj_parity_err), .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_mv(z_rsp_mv), .rsp_mc(z_rsp_mc), .err_count(z_err_count)
    );

    // Reference model: the access rules applied to a plain byte array.
    function automatic void model(input bit we, input int a, input logic [7:0] wd,
                                  input bit rom, input bit inj,
                                  output logic [7:0] rd, output logic mv, output logic mc);
        rd = 8'h00; mv = 1'b0; mc = 1'b0;
        if (a >= DEPTH) begin
            mv = 1'b1;
        end else if (we) begin
            if (a >= ROMB && !rom) begin
                mv = 1'b1;
            end else begin
                m_data[a] = wd;
                m_bad[a]  = inj;
                wr_q.push_back(a);
            end
        end else begin
            rd = m_data[a];
            mc = m_bad[a];
        end
        if ((mv || mc) && m_err < 255) m_err++;
    endfunction

    // Issues one request from a negedge, returns the response and the number
    // of negedges after the accept edge until rsp_valid was seen.
    task automatic xact(input logic we, input logic [19:0] a, input logic [7:0] wd,
                        input logic rom, input logic inj,
                        output logic [7:0] rd, output logic mv, output logic mc, output int lat);
        int guard = 0;
        rd = '0; mv = 1'b0; mc = 1'b0; lat = 0;
        while (!t_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        rom_wr_en = rom; inj_parity_err = inj; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = 20'($urandom);
        req_wdata = 8'($urandom); rom_wr_en = 1'($urandom); inj_parity_err = 1'($urandom);
        do begin
            @(negedge clk);
            lat++;
        end while (!t_rsp_valid && lat < 40);
        if (!t_rsp_valid) begin
            n_tests++; n_fail++;
            $display("FAIL xact_timeout: rsp_valid=%b required 1 (addr %h)", t_rsp_valid, a);
        end
        rd = t_rsp_rdata; mv = t_rsp_mv; mc = t_rsp_mc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_mv, a_rsp_mc, a_err_count} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b vld=%b rd=%h mv=%b mc=%b err=%0d required all 0",
                     a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_mv, a_rsp_mc, a_err_count);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: req_ready=%b rsp_valid=%b required 1/0", a_req_ready, a_rsp_valid);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rd, erd; logic mv, mc, emv, emc; int lat;
        model(1, 'h10, 8'h5A, 0, 0, erd, emv, emc);
        xact(1, 20'h00010, 8'h5A, 0, 0, rd, mv, mc, lat);
        n_tests++;
        // rsp_valid must be high when sampled by the requester at edge T+W+2
        if (lat !== W + 2 || rd !== 8'h00 || mv !== 1'b0) begin
            n_fail++;
            $display("FAIL write_latency: lat=%0d rd=%h mv=%b required %0d/00/0", lat, rd, mv, W + 2);
        end
        model(0, 'h10, 8'h00, 0, 0, erd, emv, emc);
        xact(0, 20'h00010, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (rd !== 8'h5A || mv !== 1'b0 || mc !== 1'b0 || t_err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL read_back: rd=%h mv=%b mc=%b err=%0d required 5a/0/0/0", rd, mv, mc, t_err_count);
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] rd, erd; logic mv, mc, emv, emc; int lat;
        model(0, 'h400, 8'h00, 0, 0, erd, emv, emc);
        xact(0, 20'h00400, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (mv !== 1'b1 || rd !== 8'h00 || t_err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL unmapped_400: mv=%b rd=%h err=%0d required 1/00/1", mv, rd, t_err_count);
        end
        model(0, 'hFFFFF, 8'h00, 0, 0, erd, emv, emc);
        xact(0, 20'hFFFFF, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (mv !== 1'b1 || rd !== 8'h00 || t_err_count !== 8'd2) begin
            n_fail++;
            $display("FAIL unmapped_top: mv=%b rd=%h err=%0d required 1/00/2", mv, rd, t_err_count);
        end
    endtask

    task automatic test_protect();
        logic [7:0] rd, erd; logic mv, mc, emv, emc; int lat;
        model(1, 'h3F5, 8'h3C, 1, 0, erd, emv, emc);
        xact(1, 20'h003F5, 8'h3C, 1, 0, rd, mv, mc, lat);
        n_tests++;
        if (mv !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_write: mv=%b required 0", mv);
        end
        model(1, 'h3F5, 8'hFF, 0, 0, erd, emv, emc);
        xact(1, 20'h003F5, 8'hFF, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (mv !== 1'b1 || t_err_count !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL protected_write: mv=%b err=%0d required 1/%0d", mv, t_err_count, m_err);
        end
        model(1, 'h3EF, 8'h66, 0, 0, erd, emv, emc);
        xact(1, 20'h003EF, 8'h66, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (mv !== 1'b0) begin
            n_fail++;
            $display("FAIL below_rom_write: mv=%b required 0", mv);
        end
        model(0, 'h3F5, 8'h00, 0, 0, erd, emv, emc);
        xact(0, 20'h003F5, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (rd !== 8'h3C || mv !== 1'b0) begin
            n_fail++;
            $display("FAIL protected_read: rd=%h mv=%b required 3c/0", rd, mv);
        end
    endtask

    task automatic test_parity();
        logic [7:0] rd, erd; logic mv, mc, emv, emc; int lat;
        model(1, 'h20, 8'hA5, 0, 1, erd, emv, emc);
        xact(1, 20'h00020, 8'hA5, 0, 1, rd, mv, mc, lat);
        model(0, 'h20, 8'h00, 0, 0, erd, emv, emc);
        xact(0, 20'h00020, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (rd !== 8'hA5 || mc !== 1'b1 || mv !== 1'b0 || t_err_count !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL parity_inject: rd=%h mc=%b mv=%b err=%0d required a5/1/0/%0d",
                     rd, mc, mv, t_err_count, m_err);
        end
        model(1, 'h20, 8'hA5, 0, 0, erd, emv, emc);
        xact(1, 20'h00020, 8'hA5, 0, 0, rd, mv, mc, lat);
        model(0, 'h20, 8'h00, 0, 0, erd, emv, emc);
        xact(0, 20'h00020, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (rd !== 8'hA5 || mc !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_clean: rd=%h mc=%b required a5/0", rd, mc);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] erd; logic emv, emc; int guard = 0; bit bad = 0;
        model(0, 'h10, 8'h00, 0, 0, erd, emv, emc);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00010; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!a_rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            if (a_rsp_valid !== 1'b1 || a_req_ready !== 1'b0 || a_rsp_rdata !== erd ||
                a_rsp_mv !== 1'b0 || a_rsp_mc !== 1'b0) bad = 1;
            req_valid = 1'(i % 2); req_we = 1'b1; req_addr = 20'h00010; req_wdata = 8'hEE;
            @(negedge clk);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL backpressure_hold: vld=%b rdy=%b rd=%h required 1/0/%h",
                     a_rsp_valid, a_req_ready, a_rsp_rdata, erd);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%b rdy=%b required 0/1", a_rsp_valid, a_req_ready);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_rsp_valid !== 1'b0) bad = 1;
            @(negedge clk);
        end
        n_tests++;
        if (bad || a_rsp_rdata !== erd) begin
            n_fail++;
            $display("FAIL ignored_pulses: extra response seen rd=%h required none", a_rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd, erd; logic mv, mc, emv, emc; int lat; bit bad = 0;
        model(1, 'h30, 8'h11, 0, 0, erd, emv, emc);
        xact(1, 20'h00030, 8'h11, 0, 0, rd, mv, mc, lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00030; req_wdata = 8'h77; rom_wr_en = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_mv, a_rsp_mc, a_err_count} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: rdy=%b vld=%b rd=%h mv=%b mc=%b err=%0d required all 0",
                     a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_mv, a_rsp_mc, a_err_count);
        end
        m_err = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_rsp_valid !== 1'b0) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_no_rsp: rsp_valid seen 1 required 0");
        end
        model(0, 'h30, 8'h00, 0, 0, erd, emv, emc);
        xact(0, 20'h00030, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (rd !== 8'h11 || mv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop_write: rd=%h mv=%b required 11/0", rd, mv);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, erd, wd; logic mv, mc, emv, emc; int lat, a; bit we, rom, inj;
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom);
            rom = 1'($urandom);
            inj = ($urandom_range(0, 3) == 0);
            wd  = 8'($urandom);
            case ($urandom_range(0, 2))
                0: a = $urandom_range(0, ROMB - 1);
                1: a = $urandom_range(ROMB, DEPTH - 1);
                default: a = $urandom_range(DEPTH, 20'hFFFFF);
            endcase
            if (!we && a < DEPTH) a = wr_q[$urandom_range(0, wr_q.size() - 1)];
            model(we, a, wd, rom, inj, erd, emv, emc);
            xact(we, 20'(a), wd, rom, inj, rd, mv, mc, lat);
            n_tests++;
            if (rd !== erd || mv !== emv || mc !== emc || t_err_count !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL random_%0d: we=%b a=%h rd=%h mv=%b mc=%b err=%0d required %h/%b/%b/%0d",
                         i, we, a, rd, mv, mc, t_err_count, erd, emv, emc, m_err);
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] rd, erd; logic mv, mc, emv, emc; int lat;
        for (int i = 0; i < 260; i++) begin
            model(0, 'h800, 8'h00, 0, 0, erd, emv, emc);
            xact(0, 20'h00800, 8'h00, 0, 0, rd, mv, mc, lat);
        end
        n_tests++;
        if (t_err_count !== 8'd255 || m_err != 255) begin
            n_fail++;
            $display("FAIL err_saturate: err=%0d required 255", t_err_count);
        end
    endtask

    task automatic test_wait0();
        logic [7:0] rd; logic mv, mc; int lat;
        use0 = 1'b1;
        @(negedge clk);
        xact(1, 20'h00050, 8'h42, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (lat !== 2 || mv !== 1'b0) begin
            n_fail++;
            $display("FAIL wait0_latency: lat=%0d mv=%b required 2/0", lat, mv);
        end
        xact(0, 20'h00050, 8'h00, 0, 0, rd, mv, mc, lat);
        n_tests++;
        if (rd !== 8'h42 || lat !== 2 || mc !== 1'b0) begin
            n_fail++;
            $display("FAIL wait0_read: rd=%h lat=%0d mc=%b required 42/2/0", rd, lat, mc);
        end
        use0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; use0 = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rom_wr_en = 1'b0; inj_parity_err = 1'b0; rsp_ready = 1'b1;
        m_err = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = 8'h00;
            m_bad[i]  = 1'b0;
        end
        test_reset();
        test_write_read();
        test_unmapped();
        test_protect();
        test_parity();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wait0();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
